// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the multicycle RV32 control path: state codes, opcodes,
// immediate formats and datapath mux selects.
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StLui      = 4'd11,
        StTrap     = 4'd12
    } state_e;

    // Instruction class as seen by DECODE.
    typedef enum logic [2:0] {
        ClsMem,
        ClsAluR,
        ClsAluI,
        ClsBranch,
        ClsJal,
        ClsLui,
        ClsTrap
    } op_class_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAluR   = 7'b0110011;
    localparam logic [6:0] OpAluI   = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] F3Beq = 3'b000;
    localparam logic [2:0] F3Bne = 3'b001;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    localparam logic AdrPc  = 1'b0;
    localparam logic AdrAlu = 1'b1;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResRdata  = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

endpackage

// File: rtl/control_fsm_if.sv
// Memory request/handshake bundle between the control FSM and the memory port.
interface control_fsm_if;

    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        output mem_ready
    );

endinterface

// File: rtl/ctrl_opdecode.sv
// Opcode/funct3 decode: immediate format, DECODE successor class and legality.
module ctrl_opdecode
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [2:0] imm_src,
    output op_class_e  op_class,
    output logic       legal
);

    always_comb begin
        imm_src  = ImmI;
        op_class = ClsTrap;
        legal    = 1'b0;
        case (opcode)
            OpLoad: begin
                op_class = ClsMem;
                legal    = 1'b1;
            end
            OpStore: begin
                imm_src  = ImmS;
                op_class = ClsMem;
                legal    = 1'b1;
            end
            OpAluR: begin
                op_class = ClsAluR;
                legal    = 1'b1;
            end
            OpAluI: begin
                op_class = ClsAluI;
                legal    = 1'b1;
            end
            OpBranch: begin
                imm_src = ImmB;
                // Only beq/bne are implemented; other compares trap.
                if (funct3 == F3Beq || funct3 == F3Bne) begin
                    op_class = ClsBranch;
                    legal    = 1'b1;
                end
            end
            OpJal: begin
                imm_src  = ImmJ;
                op_class = ClsJal;
                legal    = 1'b1;
            end
            OpLui: begin
                imm_src  = ImmU;
                op_class = ClsLui;
                legal    = 1'b1;
            end
            default: begin
                imm_src = ImmI;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32 control FSM: sequences fetch, decode, memory, ALU, branch and
// jump phases and drives the datapath selects.
module control_fsm
    import rv32_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic          zero,
    control_fsm_if.master mem,
    output logic          ir_write,
    output logic          pc_write,
    output logic          reg_write,
    output logic [1:0]    alu_src_a,
    output logic [1:0]    alu_src_b,
    output logic [1:0]    alu_op,
    output logic [1:0]    result_src,
    output logic [2:0]    imm_src,
    output logic          illegal,
    output logic [3:0]    state
);

    state_e    state_q, state_d;
    op_class_e op_class;
    logic      legal;

    logic req, we, adr, irw, pcw, rw, ill;

    ctrl_opdecode u_opdecode (
        .opcode   (opcode),
        .funct3   (funct3),
        .imm_src  (imm_src),
        .op_class (op_class),
        .legal    (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        we         = 1'b0;
        adr        = AdrPc;
        irw        = 1'b0;
        pcw        = 1'b0;
        rw         = 1'b0;
        ill        = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluAdd;
        result_src = ResAluOut;

        case (state_q)
            StFetch: begin
                req        = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAlu;
                irw        = mem.mem_ready;
                pcw        = mem.mem_ready;
                if (mem.mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Precompute the branch/jump target into ALU-out.
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                if (!legal) begin
                    state_d = StTrap;
                end else begin
                    case (op_class)
                        ClsMem:    state_d = StMemAdr;
                        ClsAluR:   state_d = StExecR;
                        ClsAluI:   state_d = StExecI;
                        ClsBranch: state_d = StBranch;
                        ClsJal:    state_d = StJal;
                        ClsLui:    state_d = StLui;
                        default:   state_d = StTrap;
                    endcase
                end
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = (opcode == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                req = 1'b1;
                adr = AdrAlu;
                if (mem.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = ResRdata;
                rw         = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                req = 1'b1;
                we  = 1'b1;
                adr = AdrAlu;
                if (mem.mem_ready) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                rw         = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBRs2;
                alu_op     = AluSub;
                result_src = ResAluOut;
                pcw        = (funct3 == F3Beq) ? zero : ~zero;
                state_d    = StFetch;
            end
            StJal: begin
                // Target was computed in DECODE; link value is old PC + 4.
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pcw        = 1'b1;
                state_d    = StAluWb;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
                state_d   = StAluWb;
            end
            StTrap: begin
                ill     = 1'b1;
                state_d = StFetch;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Strobes are forced low for the whole reset window, not just after the edge.
    assign mem.mem_req = req & rst_n;
    assign mem.mem_we  = we & rst_n;
    assign mem.adr_src = adr;
    assign ir_write    = irw & rst_n;
    assign pc_write    = pcw & rst_n;
    assign reg_write   = rw & rst_n;
    assign illegal     = ill & rst_n;
    assign state       = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed scenarios plus randomized instruction
// stream checked every cycle against a path-based behavioural model.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0;
    logic       ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic [3:0] state;

    control_fsm_if mif();

    control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem        (mif),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: current phase number and the phases still to visit for this instruction.
    int cur = 0;
    int path[$];

    logic [21:0] tr[16];
    logic [21:0] obs;

    logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b0110111, 7'b0010111, 7'b0000000};
    int add_states[5] = '{0, 1, 6, 8, 0};
    logic [6:0] sweep_op[5] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
    logic [2:0] sweep_imm[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    int sweep_len[5] = '{6, 5, 4, 5, 5};
    logic [15:0] sweep_rdy[5] = '{16'h001F, 16'h000F, 16'h0007, 16'h000F, 16'h000F};

    // Layout: req we adr irw pcw rw a[2] b[2] op[2] rs[2] imm[3] ill state[4]
    function automatic logic [21:0] dut_vec();
        return {mif.mem_req, mif.mem_we, mif.adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal, state};
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [21:0] expect_vec();
        logic req, we, adr, irw, pcw, rw, ill;
        logic [1:0] a, b, op, rs;
        logic [3:0] s;
        req = 0; we = 0; adr = 0; irw = 0; pcw = 0; rw = 0; ill = 0;
        a = 0; b = 0; op = 0; rs = 0;
        s = 4'(cur);
        case (cur)
            0:  begin req = 1; b = 2; rs = 2; irw = mif.mem_ready; pcw = mif.mem_ready; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  begin req = 1; adr = 1; end
            4:  begin rs = 1; rw = 1; end
            5:  begin req = 1; we = 1; adr = 1; end
            6:  begin a = 2; op = 2; end
            7:  begin a = 2; b = 1; op = 2; end
            8:  rw = 1;
            9:  begin a = 2; op = 1; pcw = (funct3 == 3'b000) ? zero : ~zero; end
            10: begin a = 1; b = 2; pcw = 1; end
            11: begin a = 3; b = 1; end
            12: ill = 1;
            default: ;
        endcase
        if (!rst_n) begin
            req = 0; we = 0; irw = 0; pcw = 0; rw = 0; ill = 0;
        end
        return {req, we, adr, irw, pcw, rw, a, b, op, rs, exp_imm(opcode), ill, s};
    endfunction

    // Phases an instruction walks through after its fetch completes.
    task automatic build_path();
        path.delete();
        path.push_back(1);
        case (opcode)
            7'b0000011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            7'b0100011: begin path.push_back(2); path.push_back(5); end
            7'b0110011: begin path.push_back(6); path.push_back(8); end
            7'b0010011: begin path.push_back(7); path.push_back(8); end
            7'b1100011: path.push_back((funct3 < 3'd2) ? 9 : 12);
            7'b1101111: begin path.push_back(10); path.push_back(8); end
            7'b0110111: begin path.push_back(11); path.push_back(8); end
            default:    path.push_back(12);
        endcase
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            cur = 0;
            path.delete();
        end else if ((cur == 0 || cur == 3 || cur == 5) && !mif.mem_ready) begin
            cur = cur;
        end else begin
            if (cur == 0) build_path();
            if (path.size() == 0) cur = 0;
            else cur = path.pop_front();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(input logic rdy, input logic z, input int idx);
        mif.mem_ready = rdy;
        zero = z;
        @(negedge clk);
        obs = dut_vec();
        if (idx >= 0 && idx < 16) tr[idx] = obs;
        chk("per-cycle outputs", 32'(obs), 32'(expect_vec()));
        @(posedge clk);
        model_advance();
        cyc++;
        #1;
    endtask

    task automatic run_fixed(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int n, input logic [15:0] rdy);
        opcode = op;
        funct3 = f3;
        for (int i = 0; i < n; i++) cycle(rdy[i], z, i);
    endtask

    initial begin
        int cnt;
        mif.mem_ready = 1'b1;

        // Reset held low: strobes quiet, FETCH selects visible.
        cycle(1'b1, 1'b0, 0);
        chk("reset state", 32'(tr[0][3:0]), 0);
        chk("reset mem_req", 32'(tr[0][21]), 0);
        chk("reset ir_write", 32'(tr[0][18]), 0);
        chk("reset alu_src_b", 32'(tr[0][13:12]), 2);
        cycle(1'b1, 1'b0, -1);
        rst_n = 1'b1;

        // add: 0,1,6,8,0 with reg_write only in the fourth cycle.
        run_fixed(7'b0110011, 3'b000, 1'b0, 5, 16'h000F);
        for (int i = 0; i < 5; i++) begin
            chk("add state trace", 32'(tr[i][3:0]), 32'(add_states[i]));
            chk("add reg_write", 32'(tr[i][16]), (i == 3) ? 1 : 0);
        end

        // lw with three wait cycles in MEMREAD.
        run_fixed(7'b0000011, 3'b010, 1'b0, 9, 16'h00C7);
        cnt = 0;
        for (int i = 0; i < 9; i++) if (tr[i][21] && tr[i][19]) cnt++;
        chk("lw request held cycles", 32'(cnt), 4);
        chk("lw memwb state", 32'(tr[7][3:0]), 4);
        chk("lw memwb reg_write", 32'(tr[7][16]), 1);
        chk("lw memwb result_src", 32'(tr[7][9:8]), 1);
        chk("lw no write during wait", 32'(tr[6][16]), 0);

        // beq taken / bne not taken, both back in FETCH after three cycles.
        run_fixed(7'b1100011, 3'b000, 1'b1, 4, 16'h0007);
        chk("beq pc_write", 32'(tr[2][17]), 1);
        chk("beq branch state", 32'(tr[2][3:0]), 9);
        chk("beq back to fetch", 32'(tr[3][3:0]), 0);
        run_fixed(7'b1100011, 3'b001, 1'b1, 4, 16'h0007);
        chk("bne pc_write", 32'(tr[2][17]), 0);
        chk("bne back to fetch", 32'(tr[3][3:0]), 0);

        // Unsupported opcode traps for exactly one cycle with no writes.
        run_fixed(7'b0010111, 3'b000, 1'b0, 4, 16'h0007);
        chk("trap state", 32'(tr[2][3:0]), 12);
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += 32'(tr[i][4]);
        chk("trap illegal pulses", 32'(cnt), 1);
        chk("trap no writes", 32'({tr[1][21:20], tr[1][17:16], tr[2][21:20], tr[2][17:16]}), 0);
        chk("trap returns to fetch", 32'(tr[3][3:0]), 0);

        // imm_src sweep across every phase of each instruction.
        for (int k = 0; k < 5; k++) begin
            run_fixed(sweep_op[k], 3'b000, 1'b0, sweep_len[k], sweep_rdy[k]);
            for (int i = 0; i < sweep_len[k]; i++)
                chk($sformatf("imm_src op %b", sweep_op[k]), 32'(tr[i][7:5]), 32'(sweep_imm[k]));
        end

        // Reset in the middle of a stalled store.
        run_fixed(7'b0100011, 3'b010, 1'b0, 5, 16'h0007);
        chk("sw waiting in memwrite", 32'(tr[4][3:0]), 5);
        rst_n = 1'b0;
        #1;
        chk("async reset mem_req", 32'(mif.mem_req), 0);
        chk("async reset mem_we", 32'(mif.mem_we), 0);
        chk("async reset state", 32'(state), 0);
        cur = 0;
        path.delete();
        cycle(1'b1, 1'b0, -1);
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 0);
        chk("post-reset fetch mem_req", 32'(tr[0][21]), 1);
        chk("post-reset fetch adr_src", 32'(tr[0][19]), 0);

        // Randomized instruction stream with random stalls and zero flag.
        for (int n = 0; n < 4000; n++) begin
            if (cur == 0) begin
                int k;
                k = int'($urandom_range(0, 9));
                if (k < 9) opcode = ops[k];
                else opcode = 7'($urandom);
                funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1));
            end
            cycle($urandom_range(0, 3) != 0, 1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
